// File: rtl/cpu_pkg.sv
// cpu_pkg: shared defaults and types for the register file slice.
//   DATA_W_DEF   - default register width
//   NUM_REGS_DEF - default register count
//   IMM_W_DEF    - default immediate field width
//   imm_mode_e   - immediate write mode (replace low bits / shift in)
package cpu_pkg;

    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned NUM_REGS_DEF = 4;
    localparam int unsigned IMM_W_DEF    = 4;

    typedef enum logic {
        IMM_LOW   = 1'b0,
        IMM_SHIFT = 1'b1
    } imm_mode_e;

endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-load scoreboard with stall detection and a
// saturating stall-cycle counter.
//   clk, rst_n            - clock, asynchronous active-low reset
//   pend_set, pend_reg    - mark a register pending (load issued)
//   pend_clr, pend_clr_reg- clear a pending register (load returned)
//   src_a, src_b          - source register addresses being read
//   stall                 - a source is pending and not returning this cycle
//   pending               - scoreboard bit vector
//   stall_cnt             - saturating count of stall cycles
module reg_scoreboard #(
    parameter int NUM_REGS = 4,
    parameter bit ZERO_R0  = 1'b0,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pend_set,
    input  logic [AW-1:0]       pend_reg,
    input  logic                pend_clr,
    input  logic [AW-1:0]       pend_clr_reg,
    input  logic [AW-1:0]       src_a,
    input  logic [AW-1:0]       src_b,
    output logic                stall,
    output logic [NUM_REGS-1:0] pending,
    output logic [15:0]         stall_cnt
);

    logic [NUM_REGS-1:0] pending_q, pending_d;
    logic [15:0]         stall_cnt_q, stall_cnt_d;
    logic                blocked_a, blocked_b;

    always_comb begin
        // Clear first so a same-register set on the same edge wins.
        pending_d = pending_q;
        if (pend_clr) begin
            pending_d[pend_clr_reg] = 1'b0;
        end
        if (pend_set && !(ZERO_R0 && pend_reg == '0)) begin
            pending_d[pend_reg] = 1'b1;
        end

        // A register returning this cycle is forwarded, so it never blocks.
        blocked_a = pending_q[src_a] && !(pend_clr && pend_clr_reg == src_a);
        blocked_b = pending_q[src_b] && !(pend_clr && pend_clr_reg == src_b);
        if (ZERO_R0 && src_a == '0) begin
            blocked_a = 1'b0;
        end
        if (ZERO_R0 && src_b == '0) begin
            blocked_b = 1'b0;
        end

        stall = rst_n && (blocked_a || blocked_b);

        stall_cnt_d = stall_cnt_q;
        if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pending   = pending_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: two-read, one-write register file with immediate-merge
// writes, optional write-to-read bypass, optional hardwired-zero r0 and a
// pending-load scoreboard.
//   CLK, Reset_n           - clock, asynchronous active-low reset
//   srcA, srcB             - read addresses
//   WriteReg, RegWriteCtrl - write address and enable
//   LoadImm, ImmMode       - immediate write select and mode
//   WriteData              - write data / immediate in the low IMM_W bits
//   PendSet, PendReg       - mark a register pending
//   PendClr, PendClrReg    - clear a pending register
//   ReadA, ReadB           - read data
//   Stall, Pending, StallCnt - scoreboard status
module reg_file_sb
    import cpu_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int IMM_W    = IMM_W_DEF,
    parameter bit ZERO_R0  = 1'b0,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                CLK,
    input  logic                Reset_n,
    input  logic [AW-1:0]       srcA,
    input  logic [AW-1:0]       srcB,
    input  logic [AW-1:0]       WriteReg,
    input  logic                RegWriteCtrl,
    input  logic                LoadImm,
    input  logic                ImmMode,
    input  logic [DATA_W-1:0]   WriteData,
    input  logic                PendSet,
    input  logic [AW-1:0]       PendReg,
    input  logic                PendClr,
    input  logic [AW-1:0]       PendClrReg,
    output logic [DATA_W-1:0]   ReadA,
    output logic [DATA_W-1:0]   ReadB,
    output logic                Stall,
    output logic [NUM_REGS-1:0] Pending,
    output logic [15:0]         StallCnt
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [DATA_W-1:0] wr_old, wr_val;
    logic [IMM_W-1:0]  imm;
    imm_mode_e         imm_mode;
    logic              wr_en;
    logic [AW-1:0]     src [2];
    logic [DATA_W-1:0] rd  [2];

    // Write path: merge the immediate into the current register contents.
    always_comb begin
        imm_mode = imm_mode_e'(ImmMode);
        imm      = WriteData[IMM_W-1:0];
        wr_old   = regs_q[WriteReg];
        wr_val   = WriteData;
        if (LoadImm) begin
            if (imm_mode == IMM_SHIFT) begin
                wr_val = {wr_old[DATA_W-IMM_W-1:0], imm};
            end else begin
                wr_val = {wr_old[DATA_W-1:IMM_W], imm};
            end
        end

        wr_en = RegWriteCtrl && !(ZERO_R0 && WriteReg == '0);

        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en) begin
            regs_d[WriteReg] = wr_val;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    // Read path: an active write takes priority over a returning load's
    // forwarded data; r0 and reset force zero last.
    always_comb begin
        src[0] = srcA;
        src[1] = srcB;
        for (int unsigned p = 0; p < 2; p++) begin
            rd[p] = regs_q[src[p]];
            if (BYPASS) begin
                if (wr_en && WriteReg == src[p]) begin
                    rd[p] = wr_val;
                end else if (PendClr && PendClrReg == src[p]) begin
                    rd[p] = WriteData;
                end
            end
            if (!Reset_n || (ZERO_R0 && src[p] == '0)) begin
                rd[p] = '0;
            end
        end
    end

    assign ReadA = rd[0];
    assign ReadB = rd[1];

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ZERO_R0  (ZERO_R0)
    ) u_scoreboard (
        .clk          (CLK),
        .rst_n        (Reset_n),
        .pend_set     (PendSet),
        .pend_reg     (PendReg),
        .pend_clr     (PendClr),
        .pend_clr_reg (PendClrReg),
        .src_a        (srcA),
        .src_b        (srcB),
        .stall        (Stall),
        .pending      (Pending),
        .stall_cnt    (StallCnt)
    );

endmodule
